// File: rtl/uart_boot_loader_pkg.sv
// Shared IO constants for the boot path: UART bit timing, boot header layout,
// and the state encodings used by the loader FSM and its UART receiver.
package uart_boot_loader_pkg;

  // UART framing: 8N1, 921600 baud from a 50 MHz clock.
  localparam int unsigned UART_DEFAULT_CLK_PER_BAUD = 54;
  localparam int unsigned UART_DATA_BITS            = 8;

  // Boot image header: little-endian 32-bit byte count.
  localparam int unsigned BOOT_LEN_BYTES            = 4;

  typedef enum logic [2:0] {
    ST_RECV_LEN,
    ST_RECV_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, oversampled by the system clock.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   rx_async      : raw UART RX line (idle high), synchronized internally
//   byte_valid    : one-cycle pulse for each byte with a good stop bit
//   byte_data     : received byte, stable from byte_valid until the next byte
//   frame_error   : one-cycle pulse when a stop bit is sampled low
module uart_rx_byte
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned CLK_PER_BAUD = UART_DEFAULT_CLK_PER_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_async,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BAUD / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BAUD - 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // A glitch that is high again at mid-start is dropped silently.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_M1) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid  = valid_q;
  assign byte_data   = shift_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed image over UART and writes it
// word by word into instruction memory, holding the core in reset until done.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   io_input_rx : UART RX line (8N1, idle high, asynchronous)
//   en, we      : memory write enable and byte-lane write mask
//   addr, din   : word-aligned byte address and write data (0 when en=0)
//   core_reset  : high until the whole image is written
//   load_done   : image fully written
//   load_error  : oversize header or framing error (sticky until reset)
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH_IN_BYTE         = 4,
  parameter int unsigned UART_INTERNAL_CLK_PER_BAUD = UART_DEFAULT_CLK_PER_BAUD,
  parameter logic [31:0] INST_START_ADDR            = 32'h0,
  parameter int unsigned MAX_PROGRAM_BYTES          = 65536,
  localparam int unsigned WORD_WIDTH_IN_BIT         = 8 * WORD_WIDTH_IN_BYTE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_input_rx,
  output logic                          en,
  output logic [WORD_WIDTH_IN_BYTE-1:0] we,
  output logic [31:0]                   addr,
  output logic [WORD_WIDTH_IN_BIT-1:0]  din,
  output logic                          core_reset,
  output logic                          load_done,
  output logic                          load_error
);

  logic       byte_valid, frame_error;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLK_PER_BAUD (UART_INTERNAL_CLK_PER_BAUD)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_async    (io_input_rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_error (frame_error)
  );

  boot_state_e                   state_q, state_d;
  logic [31:0]                   len_q, len_d;
  logic [1:0]                    hdr_cnt_q, hdr_cnt_d;
  logic [31:0]                   byte_cnt_q, byte_cnt_d;
  logic [31:0]                   word_idx_q, word_idx_d;
  logic [WORD_WIDTH_IN_BIT-1:0]  asm_q, asm_d;
  logic [WORD_WIDTH_IN_BYTE-1:0] mask_q, mask_d;
  logic                          pend_q, pend_d;
  logic [7:0]                    pend_data_q, pend_data_d;

  logic        in_valid;
  logic [7:0]  in_data;
  logic [31:0] lane;

  // A byte landing during the one-cycle WRITE is parked and consumed next.
  assign in_valid = byte_valid | pend_q;
  assign in_data  = pend_q ? pend_data_q : byte_data;
  assign lane     = byte_cnt_q % 32'(WORD_WIDTH_IN_BYTE);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    mask_d      = mask_q;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    case (state_q)
      ST_RECV_LEN: begin
        if (frame_error) begin
          state_d = ST_ERROR;
        end else if (in_valid) begin
          len_d     = {in_data, len_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            word_idx_d = '0;
            asm_d      = '0;
            mask_d     = '0;
            if (len_d == 32'd0)                            state_d = ST_DONE;
            else if (len_d > 32'(MAX_PROGRAM_BYTES))        state_d = ST_ERROR;
            else                                           state_d = ST_RECV_DATA;
          end
        end
      end
      ST_RECV_DATA: begin
        if (frame_error) begin
          state_d = ST_ERROR;
        end else if (in_valid) begin
          for (int unsigned k = 0; k < WORD_WIDTH_IN_BYTE; k++) begin
            if (lane == k) begin
              asm_d[8*k +: 8] = in_data;
              mask_d[k]       = 1'b1;
            end
          end
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (lane == 32'(WORD_WIDTH_IN_BYTE - 1) || byte_cnt_q == len_q - 32'd1)
            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (byte_valid) begin
          pend_d      = 1'b1;
          pend_data_d = byte_data;
        end
        word_idx_d = word_idx_q + 32'd1;
        asm_d      = '0;
        mask_d     = '0;
        if (frame_error)              state_d = ST_ERROR;
        else if (byte_cnt_q == len_q) state_d = ST_DONE;
        else                          state_d = ST_RECV_DATA;
      end
      default: ; // DONE and ERROR hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RECV_LEN;
      len_q       <= '0;
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      mask_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_comb begin
    en   = 1'b0;
    we   = '0;
    addr = '0;
    din  = '0;
    if (state_q == ST_WRITE) begin
      en   = 1'b1;
      we   = mask_q;
      addr = INST_START_ADDR + 32'(word_idx_q * 32'(WORD_WIDTH_IN_BYTE));
      din  = asm_q;
    end
  end

  assign core_reset = (state_q != ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] din;
  logic        core_reset, load_done, load_error;

  uart_boot_loader #(
    .WORD_WIDTH_IN_BYTE         (4),
    .UART_INTERNAL_CLK_PER_BAUD (P),
    .INST_START_ADDR            (32'h0),
    .MAX_PROGRAM_BYTES          (65536)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_input_rx (rx),
    .en          (en),
    .we          (we),
    .addr        (addr),
    .din         (din),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int done_cyc = -1;

  logic [31:0] got_addr[$];
  logic [31:0] got_din[$];
  logic [3:0]  got_we[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_din[$];
  logic [3:0]  exp_we[$];
  logic [7:0]  img[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor and idle-bus check, sampled away from the active edge.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      got_addr.push_back(addr);
      got_din.push_back(din);
      got_we.push_back(we);
      last_wr_cyc = cyc;
    end else if (we !== 4'b0 || addr !== 32'b0 || din !== 32'b0) begin
      $display("FAIL idle_bus: we=%b addr=%h din=%h required all zero", we, addr, din);
      miscompares++;
    end
    if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  // Reference model: image bytes grouped into little-endian 4-byte words.
  task automatic build_expected();
    int n = img.size();
    exp_addr.delete(); exp_din.delete(); exp_we.delete();
    for (int w = 0; w < (n + 3) / 4; w++) begin
      logic [31:0] d = 0;
      int cnt = 0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < n) begin
          d = d + (32'(img[w * 4 + k]) << (8 * k));
          cnt++;
        end
      exp_addr.push_back(32'(w * 4));
      exp_din.push_back(d);
      exp_we.push_back(4'((1 << cnt) - 1));
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    got_addr.delete(); got_din.delete(); got_we.delete();
    done_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (P) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (P) @(posedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (P) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic send_header(input logic [31:0] n);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0);
  endtask

  task automatic send_img();
    for (int i = 0; i < img.size(); i++) send_byte(img[i], 1'b0);
  endtask

  task automatic wait_end();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (load_done === 1'b1 || load_error === 1'b1) break;
    end
    if (i == 4000) begin
      $display("FAIL wait_end: timeout, load_done=%b load_error=%b required one high", load_done, load_error);
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if ({en, we, addr, din, core_reset, load_done, load_error} !== {1'b0, 4'b0, 32'b0, 32'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: en=%b we=%b addr=%h din=%h cr=%b done=%b err=%b required 0 0 0 0 1 0 0",
               en, we, addr, din, core_reset, load_done, load_error);
      miscompares++;
    end
  endtask

  task automatic test_two_words();
    apply_reset();
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_expected();
    send_header(32'd8);
    send_img();
    wait_end();
    vectors++;
    if (got_addr.size() != 2) begin
      $display("FAIL two_words_count: got %0d writes required 2", got_addr.size()); miscompares++;
    end
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_din[i] !== exp_din[i] || got_we[i] !== exp_we[i]) begin
        $display("FAIL two_words_w%0d: got %h/%h/%b required %h/%h/%b", i,
                 got_addr[i], got_din[i], got_we[i], exp_addr[i], exp_din[i], exp_we[i]);
        miscompares++;
      end
    end
    vectors++;
    if (done_cyc !== last_wr_cyc + 1 || core_reset !== 1'b0 || load_done !== 1'b1) begin
      $display("FAIL two_words_done: done_cyc=%0d last_wr=%0d cr=%b done=%b required done_cyc=last_wr+1 cr=0 done=1",
               done_cyc, last_wr_cyc, core_reset, load_done);
      miscompares++;
    end
  endtask

  task automatic test_partial();
    apply_reset();
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_expected();
    send_header(32'd6);
    send_img();
    wait_end();
    vectors++;
    if (got_addr.size() != 2 || exp_din[1] !== 32'h00006655 || exp_we[1] !== 4'b0011) begin
      $display("FAIL partial_count: got %0d writes required 2", got_addr.size()); miscompares++;
    end
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_din[i] !== exp_din[i] || got_we[i] !== exp_we[i]) begin
        $display("FAIL partial_w%0d: got %h/%h/%b required %h/%h/%b", i,
                 got_addr[i], got_din[i], got_we[i], exp_addr[i], exp_din[i], exp_we[i]);
        miscompares++;
      end
    end
    vectors++;
    if (load_done !== 1'b1 || done_cyc !== last_wr_cyc + 1) begin
      $display("FAIL partial_done: done=%b done_cyc=%0d last_wr=%0d required 1, last_wr+1", load_done, done_cyc, last_wr_cyc);
      miscompares++;
    end
  endtask

  task automatic test_zero_len();
    apply_reset();
    for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b0);
    @(negedge clk);
    vectors++;
    if (load_done !== 1'b0) begin
      $display("FAIL zero_len_early: done=%b required 0 after 3 header bytes", load_done); miscompares++;
    end
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    vectors++;
    if (load_done !== 1'b1 || core_reset !== 1'b0 || got_addr.size() != 0) begin
      $display("FAIL zero_len: done=%b cr=%b writes=%0d required 1 0 0", load_done, core_reset, got_addr.size());
      miscompares++;
    end
  endtask

  task automatic test_oversize();
    apply_reset();
    send_header(32'h00010001);
    @(negedge clk);
    vectors++;
    if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin
      $display("FAIL oversize: err=%b cr=%b done=%b required 1 1 0", load_error, core_reset, load_done); miscompares++;
    end
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    vectors++;
    if (got_addr.size() != 0 || load_error !== 1'b1) begin
      $display("FAIL oversize_sticky: writes=%0d err=%b required 0 1", got_addr.size(), load_error); miscompares++;
    end
  endtask

  task automatic test_max_len();
    logic [31:0] w;
    apply_reset();
    send_header(32'h00010000);
    @(negedge clk);
    vectors++;
    if (load_error !== 1'b0 || load_done !== 1'b0 || core_reset !== 1'b1) begin
      $display("FAIL max_len_accept: err=%b done=%b cr=%b required 0 0 1", load_error, load_done, core_reset); miscompares++;
    end
    w = $urandom;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
    @(negedge clk);
    vectors++;
    if (got_addr.size() != 1 || (got_addr.size() == 1 && (got_din[0] !== w || got_we[0] !== 4'b1111 || got_addr[0] !== 32'h0))) begin
      $display("FAIL max_len_first_word: writes=%0d required 1 write of %h/1111 at 0", got_addr.size(), w); miscompares++;
    end
  endtask

  task automatic test_frame_error();
    apply_reset();
    send_header(32'd8);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b1);
    repeat (2 * P) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (load_error !== 1'b1 || core_reset !== 1'b1) begin
      $display("FAIL frame_error: err=%b cr=%b required 1 1", load_error, core_reset); miscompares++;
    end
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    vectors++;
    if (got_addr.size() != 0 || load_error !== 1'b1 || load_done !== 1'b0) begin
      $display("FAIL frame_error_sticky: writes=%0d err=%b done=%b required 0 1 0", got_addr.size(), load_error, load_done);
      miscompares++;
    end
  endtask

  task automatic test_reset_midload();
    apply_reset();
    send_header(32'd8);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    apply_reset();
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_expected();
    send_header(32'd8);
    send_img();
    wait_end();
    vectors++;
    if (got_addr.size() != 2) begin
      $display("FAIL reset_midload_count: got %0d writes required 2", got_addr.size()); miscompares++;
    end
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_din[i] !== exp_din[i] || got_we[i] !== exp_we[i]) begin
        $display("FAIL reset_midload_w%0d: got %h/%h/%b required %h/%h/%b", i,
                 got_addr[i], got_din[i], got_we[i], exp_addr[i], exp_din[i], exp_we[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 19);
      apply_reset();
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      build_expected();
      send_header(32'(n));
      send_img();
      wait_end();
      vectors++;
      if (got_addr.size() != exp_addr.size()) begin
        $display("FAIL random_count_it%0d: got %0d writes required %0d (n=%0d)", it, got_addr.size(), exp_addr.size(), n);
        miscompares++;
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        vectors++;
        if (got_addr[i] !== exp_addr[i] || got_din[i] !== exp_din[i] || got_we[i] !== exp_we[i]) begin
          $display("FAIL random_it%0d_w%0d: got %h/%h/%b required %h/%h/%b", it, i,
                   got_addr[i], got_din[i], got_we[i], exp_addr[i], exp_din[i], exp_we[i]);
          miscompares++;
        end
      end
      vectors++;
      if (load_done !== 1'b1 || load_error !== 1'b0 || done_cyc !== last_wr_cyc + 1) begin
        $display("FAIL random_done_it%0d: done=%b err=%b done_cyc=%0d last_wr=%0d required 1 0 last_wr+1",
                 it, load_done, load_error, done_cyc, last_wr_cyc);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial();
    test_zero_len();
    test_oversize();
    test_max_len();
    test_frame_error();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
